imem_loader: RTL and testbench

- Nibble-serial program loader: the write side of the processor's 16x8 instruction memory.
- Host drives 4-bit nibbles plus a strobe on spare input pins. The block assembles 8-bit instruction words and writes them sequentially to imem addresses 0..IMEM_SZ-1.
- Holds the CPU (cpu_hold_out) for the whole load. The CPU core consumes the written words unchanged.

---
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - nibble-serial loader that writes the 16x8 instruction memory
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (trailing checksum byte, err_out)
module imem_loader #(
  parameter int IMEM_SZ     = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req_in,
  input  logic              strobe_in,
  input  logic [3:0]        nibble_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  output logic              cpu_hold_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [ADDR_W:0]   count_out,
  output logic              err_out
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(IMEM_SZ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_WRITE, S_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK_LO, S_CHK_HI
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                prev_q;
  logic                stb_q;
  logic [3:0]          lo_q, lo_d;
  logic [CW-1:0]       count_q, count_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  logic                err_q, err_d;
`endif

  // Synchronizer and previous-value flop reset high so a strobe held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      prev_q    <= 1'b1;
      stb_q     <= 1'b0;
      state_q   <= S_IDLE;
      lo_q      <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], strobe_in};
      prev_q    <= sync_q[SYNC_STAGES-1];
      stb_q     <= sync_q[SYNC_STAGES-1] & ~prev_q;
      state_q   <= state_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_req_in) begin
          state_d = S_LO;
          count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LO: begin
        if (!load_req_in) begin
          state_d = S_IDLE;
        end else if (stb_q) begin
          lo_d    = nibble_in;
          state_d = S_HI;
        end
      end
      S_HI: begin
        // Abort has priority over a coincident strobe.
        if (!load_req_in) begin
          state_d = S_IDLE;
        end else if (stb_q) begin
          wr_data_d = {nibble_in, lo_q};
          wr_addr_d = count_q[ADDR_W-1:0];
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + wr_data_q;
`endif
        if (!load_req_in) begin
          state_d = S_IDLE;
        end else if (count_q == LAST) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK_LO;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_LO;
        end
      end
      S_DONE: begin
        if (!load_req_in) state_d = S_IDLE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK_LO: begin
        if (!load_req_in) begin
          state_d = S_IDLE;
        end else if (stb_q) begin
          lo_d    = nibble_in;
          state_d = S_CHK_HI;
        end
      end
      S_CHK_HI: begin
        if (!load_req_in) begin
          state_d = S_IDLE;
        end else if (stb_q) begin
          err_d   = ({nibble_in, lo_q} != sum_q);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en_out    = (state_q == S_WRITE);
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;
  assign cpu_hold_out = (state_q != S_IDLE);
  assign busy_out     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_out     = (state_q == S_DONE);
  assign count_out    = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err_out      = err_q;
`else
  assign err_out      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven bench for imem_loader
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
module tb_imem_loader;
  localparam int IMEM_SZ = 16;
  localparam int ADDR_W = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LAT = SYNC_STAGES + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_req_in = 1'b0;
  logic strobe_in = 1'b1;
  logic [3:0] nibble_in = 4'h0;
  logic wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic cpu_hold_out, busy_out, done_out, err_out;
  logic [ADDR_W:0] count_out;

  imem_loader #(.IMEM_SZ(IMEM_SZ), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .load_req_in(load_req_in), .strobe_in(strobe_in),
    .nibble_in(nibble_in), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .cpu_hold_out(cpu_hold_out), .busy_out(busy_out),
    .done_out(done_out), .count_out(count_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] data;
    logic [3:0] addr;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0] data;
    int lat;
  } wr_t;

  vec_t vecs[IMEM_SZ];
  wr_t wq[$];
  int cyc = 0;
  int rise_cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  always @(posedge clk) cyc++;

  // Record every write pulse with its latency from the most recent strobe rise.
  always @(negedge clk) begin
    if (wr_en_out) begin
      wr_t w;
      w.addr = wr_addr_out;
      w.data = wr_data_out;
      w.lat = cyc - rise_cyc;
      wq.push_back(w);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    nibble_in = n;
    @(posedge clk); #1;
    strobe_in = 1'b1;
    rise_cyc = cyc;
    repeat (LAT + 1) @(posedge clk);
    #1 strobe_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string name, input logic [3:0] addr, input logic [7:0] data);
    chk({name, "_pulses"}, wq.size(), 1);
    if (wq.size() > 0) begin
      wr_t w;
      w = wq.pop_front();
      chk({name, "_addr"}, w.addr, addr);
      chk({name, "_data"}, w.data, data);
      chk({name, "_lat"}, w.lat, LAT);
    end
  endtask

  task automatic send_word(input int i);
    send_nib(vecs[i].lo);
    send_nib(vecs[i].hi);
    check_write($sformatf("w%0d", i), vecs[i].addr, vecs[i].data);
  endtask

  task automatic start_load();
    @(posedge clk); #1 load_req_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic end_load();
    @(posedge clk); #1 load_req_in = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] prog_sum;

  initial begin
    vecs[0]  = '{4'hB, 4'h1, 8'h1B, 4'd0};
    vecs[1]  = '{4'h7, 4'h1, 8'h17, 4'd1};
    vecs[2]  = '{4'hB, 4'h1, 8'h1B, 4'd2};
    vecs[3]  = '{4'h7, 4'h3, 8'h37, 4'd3};
    vecs[4]  = '{4'hB, 4'hF, 8'hFB, 4'd4};
    vecs[5]  = '{4'h7, 4'h0, 8'h07, 4'd5};
    vecs[6]  = '{4'h1, 4'h1, 8'h11, 4'd6};
    vecs[7]  = '{4'h0, 4'h2, 8'h20, 4'd7};
    vecs[8]  = '{4'h7, 4'h2, 8'h27, 4'd8};
    vecs[9]  = '{4'h3, 4'h0, 8'h03, 4'd9};
    vecs[10] = '{4'h6, 4'h3, 8'h36, 4'd10};
    vecs[11] = '{4'h7, 4'h0, 8'h07, 4'd11};
    vecs[12] = '{4'hF, 4'h6, 8'h6F, 4'd12};
    vecs[13] = '{4'h0, 4'h0, 8'h00, 4'd13};
    vecs[14] = '{4'h0, 4'h0, 8'h00, 4'd14};
    vecs[15] = '{4'h0, 4'h0, 8'h00, 4'd15};
    prog_sum = 8'h00;
    for (int i = 0; i < IMEM_SZ; i++) prog_sum = prog_sum + vecs[i].data;

    // Reset with strobe held high, then release with strobe still high.
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 strobe_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_no_write", wq.size(), 0);
    chk("rst_hold", cpu_hold_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_count", count_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_addr", wr_addr_out, 0);
    chk("rst_data", wr_data_out, 0);

    // Full program load.
    start_load();
    chk("load_hold", cpu_hold_out, 1);
    chk("load_busy", busy_out, 1);
    for (int i = 0; i < IMEM_SZ; i++) send_word(i);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("chk_busy", busy_out, 1);
    send_nib(prog_sum[3:0]);
    send_nib(prog_sum[7:4]);
    chk("chk_ok_err", err_out, 0);
`endif
    chk("full_done", done_out, 1);
    chk("full_count", count_out, IMEM_SZ);
    chk("full_busy", busy_out, 0);
    chk("full_hold", cpu_hold_out, 1);

    // Strobes in DONE are ignored.
    send_nib(4'hA);
    send_nib(4'h5);
    chk("done_stb_no_write", wq.size(), 0);
    chk("done_stb_done", done_out, 1);

    @(posedge clk); #1 load_req_in = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("release_done", done_out, 0);
    chk("release_hold", cpu_hold_out, 0);
    chk("release_count", count_out, IMEM_SZ);

    // Abort after 5 words plus one nibble, then restart at address 0.
    start_load();
    chk("restart_count", count_out, 0);
    for (int i = 0; i < 5; i++) send_word(i);
    send_nib(4'h9);
    end_load();
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    chk("abort_no_write", wq.size(), 0);
    chk("abort_busy", busy_out, 0);
    chk("abort_hold", cpu_hold_out, 0);
    chk("abort_count", count_out, 5);
    start_load();
    send_word(0);
    chk("reload_count", count_out, 1);

    // Abort coincident with the HI-nibble strobe.
    send_nib(4'hC);
    nibble_in = 4'h3;
    @(posedge clk); #1 strobe_in = 1'b1;
    rise_cyc = cyc;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1 load_req_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 strobe_in = 1'b0;
    @(negedge clk);
    chk("coinc_no_write", wq.size(), 0);
    chk("coinc_busy", busy_out, 0);
    chk("coinc_hold", cpu_hold_out, 0);
    chk("coinc_count", count_out, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum mismatch sets err_out; next load clears it.
    start_load();
    for (int i = 0; i < IMEM_SZ; i++) send_word(i);
    send_nib(prog_sum[3:0] + 4'h1);
    send_nib(prog_sum[7:4]);
    chk("chk_bad_done", done_out, 1);
    chk("chk_bad_err", err_out, 1);
    end_load();
    chk("chk_bad_err_idle", err_out, 1);
    start_load();
    chk("chk_err_cleared", err_out, 0);
    end_load();
`endif

    // Reset in the middle of a load.
    start_load();
    send_word(0);
    send_nib(4'h4);
    @(posedge clk); #1 rst = 1'b1; load_req_in = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_hold", cpu_hold_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_count", count_out, 0);
    chk("midrst_addr", wr_addr_out, 0);
    chk("midrst_data", wr_data_out, 0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("final_no_write", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: cyc %0d, expected finish", cyc);
    $fatal(1);
  end

endmodule
